// File: rtl/uart_pkt_pkg.sv
// Shared constants and types for the UART frame parser.
// Frame layout: header, eleven payload bytes, XOR check byte, tail.
package uart_pkt_pkg;

  localparam logic [7:0] PKT_HDR         = 8'h55;
  localparam logic [7:0] PKT_TAIL        = 8'hAA;
  localparam int         PKT_PAYLOAD_LEN = 11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CRC     = 2'd2,
    ST_TAIL    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_TAIL    = 2'd1,
    ERR_CRC     = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_t;

  // Field order matches the payload byte order, so the first payload byte
  // lands in the most significant bits.
  typedef struct packed {
    logic [7:0]  reg_func;
    logic [7:0]  hs_pwm_ch;
    logic [7:0]  hs_ctrl_sta;
    logic [7:0]  duty_num;
    logic [15:0] pulse_dessert;
    logic [7:0]  pulse_num;
    logic [31:0] pat;
  } pkt_frame_t;

endpackage

// File: rtl/uart_pkt_parser_if.sv
// Bundle between the byte source and the frame parser, plus the decoded
// command fields and status going back out.
//
// Handshake: rx_valid is a one-cycle strobe qualifying rx_data. There is no
// ready; the parser accepts a byte on every cycle rx_valid is high, so
// back-to-back strobes are legal. frame_valid and err_valid are likewise
// single-cycle strobes; err_code is only meaningful while err_valid is high.
interface uart_pkt_parser_if;
  import uart_pkt_pkg::*;

  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        frame_valid;
  logic [7:0]  reg_func;
  logic [7:0]  hs_pwm_ch;
  logic [7:0]  hs_ctrl_sta;
  logic [7:0]  duty_num;
  logic [15:0] pulse_dessert;
  logic [7:0]  pulse_num;
  logic [31:0] pat;
  logic        err_valid;
  logic [1:0]  err_code;
  logic [7:0]  frame_cnt;
  logic        busy;
  state_t      dbg_state;

  modport master (
    output rx_data, rx_valid,
    input  frame_valid, reg_func, hs_pwm_ch, hs_ctrl_sta, duty_num,
           pulse_dessert, pulse_num, pat, err_valid, err_code, frame_cnt,
           busy, dbg_state
  );

  modport slave (
    input  rx_data, rx_valid,
    output frame_valid, reg_func, hs_pwm_ch, hs_ctrl_sta, duty_num,
           pulse_dessert, pulse_num, pat, err_valid, err_code, frame_cnt,
           busy, dbg_state
  );
endinterface

// File: rtl/pkt_byte_timer.sv
// Inter-byte timeout counter. Counts enabled cycles since the last clear and
// pulses o_expire on the cycle whose edge would make the count reach
// TIMEOUT_CYC. A clear in the same cycle suppresses the expiry.
module pkt_byte_timer #(
  parameter int TIMEOUT_CYC = 10000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] r_count;
  logic          w_at_limit;

  assign w_at_limit = (r_count == CW'(TIMEOUT_CYC - 1));
  assign o_expire   = i_enable && !i_clear && w_at_limit;

  // Idle-cycle counter; restarts on clear or once it has expired.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear || o_expire) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_pkt_parser.sv
// Byte-stream frame parser: finds 0x55 / 11 payload / XOR / 0xAA frames,
// validates tail and check byte, and publishes the command fields with a
// one-cycle frame_valid. Dropped frames raise err_valid with a reason code.
module uart_pkt_parser
  import uart_pkt_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int TIMEOUT_CYC = CLK_FREQ / 5000,
  parameter bit CHECK_CRC   = 1'b1
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  uart_pkt_parser_if.slave  bus
);

  localparam int SHADOW_W = PKT_PAYLOAD_LEN * 8;

  state_t                r_state;
  state_t                w_next_state;
  logic [3:0]            r_idx;
  logic [7:0]            r_xor;
  logic [7:0]            r_crc;
  logic [SHADOW_W-1:0]   r_shadow;
  pkt_frame_t            r_frame;
  logic                  r_frame_valid;
  logic                  r_err_valid;
  logic [1:0]            r_err_code;
  logic [7:0]            r_frame_cnt;

  logic                  w_timer_clear;
  logic                  w_timer_en;
  logic                  w_expire;
  logic                  w_good;
  logic                  w_drop;
  err_code_t             w_drop_code;

  // The timer only runs inside a frame; any received byte restarts it.
  assign w_timer_clear = bus.rx_valid || (r_state == ST_IDLE);
  assign w_timer_en    = (r_state != ST_IDLE);

  pkt_byte_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk      (sys_clk),
    .rst      (sys_rst),
    .i_clear  (w_timer_clear),
    .i_enable (w_timer_en),
    .o_expire (w_expire)
  );

  // State register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and frame verdict; a byte arriving always beats the timeout.
  always_comb begin
    w_next_state = r_state;
    w_good       = 1'b0;
    w_drop       = 1'b0;
    w_drop_code  = ERR_NONE;
    if (bus.rx_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (bus.rx_data == PKT_HDR) begin
            w_next_state = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (r_idx == 4'(PKT_PAYLOAD_LEN - 1)) begin
            w_next_state = ST_CRC;
          end
        end
        ST_CRC: begin
          w_next_state = ST_TAIL;
        end
        ST_TAIL: begin
          w_next_state = ST_IDLE;
          if (bus.rx_data != PKT_TAIL) begin
            w_drop      = 1'b1;
            w_drop_code = ERR_TAIL;
          end else if (CHECK_CRC && (r_crc != r_xor)) begin
            w_drop      = 1'b1;
            w_drop_code = ERR_CRC;
          end else begin
            w_good = 1'b1;
          end
        end
        default: begin
          w_next_state = ST_IDLE;
        end
      endcase
    end else if (w_expire) begin
      w_next_state = ST_IDLE;
      w_drop       = 1'b1;
      w_drop_code  = ERR_TIMEOUT;
    end
  end

  // Payload capture, check byte, published fields, strobes and frame count.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_idx         <= '0;
      r_xor         <= '0;
      r_crc         <= '0;
      r_shadow      <= '0;
      r_frame       <= '0;
      r_frame_valid <= 1'b0;
      r_err_valid   <= 1'b0;
      r_err_code    <= '0;
      r_frame_cnt   <= '0;
    end else begin
      r_frame_valid <= w_good;
      r_err_valid   <= w_drop;
      if (w_drop) begin
        r_err_code <= w_drop_code;
      end
      if (bus.rx_valid) begin
        case (r_state)
          ST_IDLE: begin
            if (bus.rx_data == PKT_HDR) begin
              r_idx <= '0;
              r_xor <= '0;
            end
          end
          ST_PAYLOAD: begin
            r_shadow <= {r_shadow[SHADOW_W-9:0], bus.rx_data};
            r_xor    <= r_xor ^ bus.rx_data;
            r_idx    <= r_idx + 1'b1;
          end
          ST_CRC: begin
            r_crc <= bus.rx_data;
          end
          default: begin
          end
        endcase
      end
      if (w_good) begin
        r_frame     <= pkt_frame_t'(r_shadow);
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  assign bus.frame_valid   = r_frame_valid;
  assign bus.reg_func      = r_frame.reg_func;
  assign bus.hs_pwm_ch     = r_frame.hs_pwm_ch;
  assign bus.hs_ctrl_sta   = r_frame.hs_ctrl_sta;
  assign bus.duty_num      = r_frame.duty_num;
  assign bus.pulse_dessert = r_frame.pulse_dessert;
  assign bus.pulse_num     = r_frame.pulse_num;
  assign bus.pat           = r_frame.pat;
  assign bus.err_valid     = r_err_valid;
  assign bus.err_code      = r_err_code;
  assign bus.frame_cnt     = r_frame_cnt;
  assign bus.busy          = (r_state != ST_IDLE);
  assign bus.dbg_state     = r_state;

endmodule

// File: tb/tb_uart_pkt_parser.sv
// Directed bench for uart_pkt_parser. Two instances share the byte stream:
// bus_a with the check byte enforced, bus_b with it ignored.
module tb_uart_pkt_parser;
  import uart_pkt_pkg::*;

  localparam int TO_CYC = 10000;
  localparam logic [87:0] PL_A = 88'h01_01_01_03_00_44_00_00_00_00_FF;
  localparam logic [87:0] PL_B = 88'h01_01_01_FF_07_30_00_FF_FF_FF_FF;

  logic       sys_clk;
  logic       sys_rst;
  logic [7:0] tb_rx_data;
  logic       tb_rx_valid;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  uart_pkt_parser_if bus_a ();
  uart_pkt_parser_if bus_b ();

  assign bus_a.rx_data  = tb_rx_data;
  assign bus_a.rx_valid = tb_rx_valid;
  assign bus_b.rx_data  = tb_rx_data;
  assign bus_b.rx_valid = tb_rx_valid;

  uart_pkt_parser #(.TIMEOUT_CYC(TO_CYC), .CHECK_CRC(1'b1)) dut_a (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus_a)
  );

  uart_pkt_parser #(.TIMEOUT_CYC(TO_CYC), .CHECK_CRC(1'b0)) dut_b (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus_b)
  );

  // Clock and reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Driver: called at a negedge, presents a byte for one edge, returns at the
  // next negedge with rx_valid low so a following call is back-to-back.
  task automatic send_byte(input logic [7:0] b);
    tb_rx_data  = b;
    tb_rx_valid = 1'b1;
    @(negedge sys_clk);
    tb_rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [87:0] pl, input logic [7:0] crc,
                            input logic [7:0] tail);
    send_byte(8'h55);
    for (int i = 0; i < 11; i++) send_byte(pl[87-8*i -: 8]);
    send_byte(crc);
    send_byte(tail);
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    tb_rx_valid = 1'b0;
    tb_rx_data = 8'h00;
    repeat (3) @(negedge sys_clk);
    checks++; if (bus_a.frame_valid !== 1'b0) begin errors++; $display("FAIL reset_frame_valid: got %b exp 0", bus_a.frame_valid); end
    checks++; if (bus_a.err_valid !== 1'b0) begin errors++; $display("FAIL reset_err_valid: got %b exp 0", bus_a.err_valid); end
    checks++; if (bus_a.err_code !== 2'd0) begin errors++; $display("FAIL reset_err_code: got %0d exp 0", bus_a.err_code); end
    checks++; if (bus_a.frame_cnt !== 8'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d exp 0", bus_a.frame_cnt); end
    checks++; if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", bus_a.busy); end
    checks++; if (bus_a.dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d exp 0", bus_a.dbg_state); end
    checks++;
    if ({bus_a.reg_func, bus_a.hs_pwm_ch, bus_a.hs_ctrl_sta, bus_a.duty_num,
         bus_a.pulse_dessert, bus_a.pulse_num, bus_a.pat} !== 88'h0) begin
      errors++; $display("FAIL reset_fields: got nonzero field outputs exp all 0");
    end
    sys_rst = 1'b0;
    @(negedge sys_clk);
  endtask

  task automatic test_good_frame();
    send_frame(PL_A, 8'hB9, 8'hAA);
    checks++; if (bus_a.frame_valid !== 1'b1) begin errors++; $display("FAIL good_frame_valid: got %b exp 1", bus_a.frame_valid); end
    checks++; if (bus_a.err_valid !== 1'b0) begin errors++; $display("FAIL good_err_valid: got %b exp 0", bus_a.err_valid); end
    checks++; if (bus_a.reg_func !== 8'h01) begin errors++; $display("FAIL good_reg_func: got %h exp 01", bus_a.reg_func); end
    checks++; if (bus_a.hs_pwm_ch !== 8'h01) begin errors++; $display("FAIL good_hs_pwm_ch: got %h exp 01", bus_a.hs_pwm_ch); end
    checks++; if (bus_a.hs_ctrl_sta !== 8'h01) begin errors++; $display("FAIL good_hs_ctrl_sta: got %h exp 01", bus_a.hs_ctrl_sta); end
    checks++; if (bus_a.duty_num !== 8'h03) begin errors++; $display("FAIL good_duty_num: got %h exp 03", bus_a.duty_num); end
    checks++; if (bus_a.pulse_dessert !== 16'h0044) begin errors++; $display("FAIL good_pulse_dessert: got %h exp 0044", bus_a.pulse_dessert); end
    checks++; if (bus_a.pulse_num !== 8'h00) begin errors++; $display("FAIL good_pulse_num: got %h exp 00", bus_a.pulse_num); end
    checks++; if (bus_a.pat !== 32'h000000FF) begin errors++; $display("FAIL good_pat: got %h exp 000000ff", bus_a.pat); end
    checks++; if (bus_a.frame_cnt !== 8'd1) begin errors++; $display("FAIL good_frame_cnt: got %0d exp 1", bus_a.frame_cnt); end
    checks++; if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL good_busy: got %b exp 0", bus_a.busy); end
    @(negedge sys_clk);
    checks++; if (bus_a.frame_valid !== 1'b0) begin errors++; $display("FAIL good_single_pulse: got %b exp 0", bus_a.frame_valid); end
    checks++; if (bus_a.duty_num !== 8'h03) begin errors++; $display("FAIL good_hold: got %h exp 03", bus_a.duty_num); end
  endtask

  task automatic test_bad_crc();
    send_frame(PL_A, 8'h0C, 8'hAA);
    checks++; if (bus_a.err_valid !== 1'b1) begin errors++; $display("FAIL crc_err_valid: got %b exp 1", bus_a.err_valid); end
    checks++; if (bus_a.err_code !== 2'd2) begin errors++; $display("FAIL crc_err_code: got %0d exp 2", bus_a.err_code); end
    checks++; if (bus_a.frame_valid !== 1'b0) begin errors++; $display("FAIL crc_frame_valid: got %b exp 0", bus_a.frame_valid); end
    checks++; if (bus_a.frame_cnt !== 8'd1) begin errors++; $display("FAIL crc_frame_cnt: got %0d exp 1", bus_a.frame_cnt); end
    checks++; if (bus_a.pat !== 32'h000000FF) begin errors++; $display("FAIL crc_fields_held: got %h exp 000000ff", bus_a.pat); end
    checks++; if (bus_b.frame_valid !== 1'b1) begin errors++; $display("FAIL nocrc_frame_valid: got %b exp 1", bus_b.frame_valid); end
    checks++; if (bus_b.err_valid !== 1'b0) begin errors++; $display("FAIL nocrc_err_valid: got %b exp 0", bus_b.err_valid); end
    checks++; if (bus_b.frame_cnt !== 8'd2) begin errors++; $display("FAIL nocrc_frame_cnt: got %0d exp 2", bus_b.frame_cnt); end
    @(negedge sys_clk);
    checks++; if (bus_a.err_valid !== 1'b0) begin errors++; $display("FAIL crc_single_pulse: got %b exp 0", bus_a.err_valid); end
  endtask

  task automatic test_garbage();
    send_byte(8'h00); @(negedge sys_clk);
    send_byte(8'h12); @(negedge sys_clk);
    send_byte(8'hAA); @(negedge sys_clk);
    checks++; if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL garbage_busy: got %b exp 0", bus_a.busy); end
    checks++; if (bus_a.err_valid !== 1'b0) begin errors++; $display("FAIL garbage_err_valid: got %b exp 0", bus_a.err_valid); end
    send_frame(PL_B, 8'hC9, 8'hAA);
    checks++; if (bus_a.frame_valid !== 1'b1) begin errors++; $display("FAIL garbage_frame_valid: got %b exp 1", bus_a.frame_valid); end
    checks++; if (bus_a.duty_num !== 8'hFF) begin errors++; $display("FAIL garbage_duty_num: got %h exp ff", bus_a.duty_num); end
    checks++; if (bus_a.pulse_dessert !== 16'h0730) begin errors++; $display("FAIL garbage_pulse_dessert: got %h exp 0730", bus_a.pulse_dessert); end
    checks++; if (bus_a.pat !== 32'hFFFFFFFF) begin errors++; $display("FAIL garbage_pat: got %h exp ffffffff", bus_a.pat); end
    checks++; if (bus_a.frame_cnt !== 8'd2) begin errors++; $display("FAIL garbage_frame_cnt: got %0d exp 2", bus_a.frame_cnt); end
    @(negedge sys_clk);
    checks++; if (bus_a.frame_valid !== 1'b0) begin errors++; $display("FAIL garbage_single_pulse: got %b exp 0", bus_a.frame_valid); end
  endtask

  task automatic test_tail_mismatch();
    send_frame(PL_A, 8'hB9, 8'hAB);
    checks++; if (bus_a.err_valid !== 1'b1) begin errors++; $display("FAIL tail_err_valid: got %b exp 1", bus_a.err_valid); end
    checks++; if (bus_a.err_code !== 2'd1) begin errors++; $display("FAIL tail_err_code: got %0d exp 1", bus_a.err_code); end
    checks++; if (bus_a.frame_cnt !== 8'd2) begin errors++; $display("FAIL tail_frame_cnt: got %0d exp 2", bus_a.frame_cnt); end
    checks++; if (bus_a.duty_num !== 8'hFF) begin errors++; $display("FAIL tail_fields_held: got %h exp ff", bus_a.duty_num); end
    send_frame(PL_A, 8'hB9, 8'hAA);
    checks++; if (bus_a.frame_valid !== 1'b1) begin errors++; $display("FAIL tail_next_valid: got %b exp 1", bus_a.frame_valid); end
    checks++; if (bus_a.duty_num !== 8'h03) begin errors++; $display("FAIL tail_next_duty: got %h exp 03", bus_a.duty_num); end
    checks++; if (bus_a.frame_cnt !== 8'd3) begin errors++; $display("FAIL tail_next_cnt: got %0d exp 3", bus_a.frame_cnt); end
    @(negedge sys_clk);
  endtask

  task automatic test_timeout();
    send_byte(8'h55);
    send_byte(8'h01);
    send_byte(8'h02);
    repeat (TO_CYC - 1) @(negedge sys_clk);
    checks++; if (bus_a.err_valid !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b exp 0", bus_a.err_valid); end
    checks++; if (bus_a.busy !== 1'b1) begin errors++; $display("FAIL timeout_busy_before: got %b exp 1", bus_a.busy); end
    @(negedge sys_clk);
    checks++; if (bus_a.err_valid !== 1'b1) begin errors++; $display("FAIL timeout_err_valid: got %b exp 1", bus_a.err_valid); end
    checks++; if (bus_a.err_code !== 2'd3) begin errors++; $display("FAIL timeout_err_code: got %0d exp 3", bus_a.err_code); end
    checks++; if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL timeout_busy_after: got %b exp 0", bus_a.busy); end
    checks++; if (bus_a.dbg_state !== ST_IDLE) begin errors++; $display("FAIL timeout_state: got %0d exp 0", bus_a.dbg_state); end
    @(negedge sys_clk);
    checks++; if (bus_a.err_valid !== 1'b0) begin errors++; $display("FAIL timeout_single_pulse: got %b exp 0", bus_a.err_valid); end
    send_frame(PL_B, 8'hC9, 8'hAA);
    checks++; if (bus_a.frame_valid !== 1'b1) begin errors++; $display("FAIL timeout_next_valid: got %b exp 1", bus_a.frame_valid); end
    checks++; if (bus_a.frame_cnt !== 8'd4) begin errors++; $display("FAIL timeout_next_cnt: got %0d exp 4", bus_a.frame_cnt); end
    @(negedge sys_clk);
  endtask

  // A byte landing on the expiry cycle must be taken and the frame survive.
  task automatic test_timeout_race();
    logic [87:0] pl;
    pl = PL_A;
    send_byte(8'h55);
    repeat (TO_CYC - 1) @(negedge sys_clk);
    send_byte(pl[87:80]);
    checks++; if (bus_a.err_valid !== 1'b0) begin errors++; $display("FAIL race_err_valid: got %b exp 0", bus_a.err_valid); end
    checks++; if (bus_a.busy !== 1'b1) begin errors++; $display("FAIL race_busy: got %b exp 1", bus_a.busy); end
    for (int i = 1; i < 11; i++) send_byte(pl[87-8*i -: 8]);
    send_byte(8'hB9);
    send_byte(8'hAA);
    checks++; if (bus_a.frame_valid !== 1'b1) begin errors++; $display("FAIL race_frame_valid: got %b exp 1", bus_a.frame_valid); end
    checks++; if (bus_a.frame_cnt !== 8'd5) begin errors++; $display("FAIL race_frame_cnt: got %0d exp 5", bus_a.frame_cnt); end
    @(negedge sys_clk);
  endtask

  task automatic test_reset_mid_frame();
    send_byte(8'h55);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    sys_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      checks++; if (bus_a.frame_valid !== 1'b0 || bus_a.err_valid !== 1'b0) begin
        errors++; $display("FAIL rstmid_strobes: got fv=%b ev=%b exp 0 0", bus_a.frame_valid, bus_a.err_valid);
      end
    end
    checks++; if (bus_a.dbg_state !== ST_IDLE) begin errors++; $display("FAIL rstmid_state: got %0d exp 0", bus_a.dbg_state); end
    checks++; if (bus_a.frame_cnt !== 8'd0) begin errors++; $display("FAIL rstmid_frame_cnt: got %0d exp 0", bus_a.frame_cnt); end
    checks++; if (bus_a.err_code !== 2'd0) begin errors++; $display("FAIL rstmid_err_code: got %0d exp 0", bus_a.err_code); end
    checks++;
    if ({bus_a.reg_func, bus_a.hs_pwm_ch, bus_a.hs_ctrl_sta, bus_a.duty_num,
         bus_a.pulse_dessert, bus_a.pulse_num, bus_a.pat} !== 88'h0) begin
      errors++; $display("FAIL rstmid_fields: got nonzero field outputs exp all 0");
    end
    sys_rst = 1'b0;
    @(negedge sys_clk);
    checks++; if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b exp 0", bus_a.busy); end
  endtask

  // 256 frames with no gap; frame_cnt must run 1..255 then wrap to 0.
  task automatic test_back_to_back();
    logic [7:0] exp_cnt;
    for (int i = 1; i <= 256; i++) exp_q.push_back(8'(i));
    for (int i = 0; i < 256; i++) begin
      send_frame(PL_A, 8'hB9, 8'hAA);
      exp_cnt = exp_q.pop_front();
      checks++; if (bus_a.frame_valid !== 1'b1) begin errors++; $display("FAIL b2b_frame_valid[%0d]: got %b exp 1", i, bus_a.frame_valid); end
      checks++; if (bus_a.frame_cnt !== exp_cnt) begin errors++; $display("FAIL b2b_frame_cnt[%0d]: got %0d exp %0d", i, bus_a.frame_cnt, exp_cnt); end
    end
    checks++; if (bus_a.frame_cnt !== 8'd0) begin errors++; $display("FAIL wrap_frame_cnt: got %0d exp 0", bus_a.frame_cnt); end
    @(negedge sys_clk);
  endtask

  // Sequencer and final report
  initial begin
    test_reset();
    test_good_frame();
    test_bad_crc();
    test_garbage();
    test_tail_mismatch();
    test_timeout();
    test_timeout_race();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
